// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, load/store and shared-memory handshake bundle.
// Rev 1.0
`default_nettype none

interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                    if_req;
  logic [ADDR_WIDTH-1:0]   if_addr;
  logic                    if_gnt;
  logic                    if_rvalid;
  logic [DATA_WIDTH-1:0]   if_rdata;
  logic                    flush;

  logic                    ls_req;
  logic                    ls_we;
  logic [ADDR_WIDTH-1:0]   ls_addr;
  logic [DATA_WIDTH-1:0]   ls_wdata;
  logic [DATA_WIDTH/8-1:0] ls_be;
  logic                    ls_gnt;
  logic                    ls_rvalid;
  logic [DATA_WIDTH-1:0]   ls_rdata;

  logic                    mem_req;
  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic [DATA_WIDTH/8-1:0] mem_be;
  logic                    mem_gnt;
  logic                    mem_rvalid;
  logic [DATA_WIDTH-1:0]   mem_rdata;

  // Arbiter view.
  modport master (
    input  if_req, if_addr, flush,
    output if_gnt, if_rvalid, if_rdata,
    input  ls_req, ls_we, ls_addr, ls_wdata, ls_be,
    output ls_gnt, ls_rvalid, ls_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  // Requester / memory side view.
  modport slave (
    output if_req, if_addr, flush,
    input  if_gnt, if_rvalid, if_rdata,
    output ls_req, ls_we, ls_addr, ls_wdata, ls_be,
    input  ls_gnt, ls_rvalid, ls_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and load/store, one transaction in flight.
// Rev 1.0
`default_nettype none

module mem_port_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 3
) (
  input  wire logic               clk,
  input  wire logic               rst,
  mem_port_arbiter_if.master      bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_LS = 2'd2
  } state_e;

  localparam logic [1:0] STARVE_MAX = 2'(STARVE_LIMIT);

  state_e     state_q, state_d;
  logic [1:0] starve_q, starve_d;
  logic       drop_q, drop_d;

  logic run;
  logic in_idle;
  logic sel_if;
  logic handshake;

  assign run     = rst;
  assign in_idle = (state_q == IDLE);

  // LS wins unless fetch has waited through STARVE_LIMIT LS grants.
  assign sel_if    = bus.if_req && (!bus.ls_req || (starve_q == STARVE_MAX));
  assign handshake = bus.mem_req && bus.mem_gnt;

  assign bus.mem_req   = run && in_idle && (bus.if_req || bus.ls_req);
  assign bus.mem_we    = sel_if ? 1'b0 : bus.ls_we;
  assign bus.mem_addr  = sel_if ? bus.if_addr : bus.ls_addr;
  assign bus.mem_wdata = bus.ls_wdata;
  assign bus.mem_be    = sel_if ? {(DATA_WIDTH/8){1'b1}} : bus.ls_be;

  assign bus.if_gnt = run && in_idle && sel_if && bus.mem_gnt;
  assign bus.ls_gnt = run && in_idle && !sel_if && bus.ls_req && bus.mem_gnt;

  // A flush on the response cycle itself must also hide the stale fetch.
  assign bus.if_rvalid = run && (state_q == BUSY_IF) && bus.mem_rvalid && !drop_q && !bus.flush;
  assign bus.ls_rvalid = run && (state_q == BUSY_LS) && bus.mem_rvalid;
  assign bus.if_rdata  = bus.mem_rdata;
  assign bus.ls_rdata  = bus.mem_rdata;

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    drop_d   = drop_q;
    case (state_q)
      IDLE: begin
        drop_d = 1'b0;
        if (handshake) begin
          if (sel_if) begin
            state_d  = BUSY_IF;
            starve_d = 2'd0;
            drop_d   = bus.flush;
          end else begin
            state_d = BUSY_LS;
            if (bus.if_req && (starve_q < STARVE_MAX)) begin
              starve_d = starve_q + 2'd1;
            end
          end
        end
      end
      BUSY_IF: begin
        if (bus.mem_rvalid) begin
          state_d = IDLE;
          drop_d  = 1'b0;
        end else if (bus.flush) begin
          drop_d = 1'b1;
        end
      end
      BUSY_LS: begin
        if (bus.mem_rvalid) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        drop_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      starve_q <= 2'd0;
      drop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      drop_q   <= drop_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed self-checking bench for mem_port_arbiter.
// Rev 1.0
`default_nettype none

module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  mem_port_arbiter #(
    .ADDR_WIDTH  (32),
    .DATA_WIDTH  (32),
    .STARVE_LIMIT(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic quiet();
    bus.if_req = 1'b0; bus.if_addr = '0; bus.flush = 1'b0;
    bus.ls_req = 1'b0; bus.ls_we = 1'b0; bus.ls_addr = '0;
    bus.ls_wdata = '0; bus.ls_be = '0;
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
  endtask

  // Expected grant pattern for the conflict run: 1 = IF, 0 = LS.
  logic [7:0] exp_if_grant  = 8'b1000_1000;
  logic [1:0] exp_starve [8] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

  initial begin
    quiet();
    // Reset holds outputs low even with live requests and grant.
    tick();
    bus.if_req = 1'b1; bus.ls_req = 1'b1; bus.mem_gnt = 1'b1;
    sample();
    check("rst_mem_req", 64'(bus.mem_req), 64'd0);
    check("rst_if_gnt",  64'(bus.if_gnt),  64'd0);
    check("rst_ls_gnt",  64'(bus.ls_gnt),  64'd0);
    tick();
    check("rst_starve",  64'(dut.starve_q), 64'd0);
    quiet();
    rst = 1'b1;
    tick();

    // Simple fetch.
    bus.if_req = 1'b1; bus.if_addr = 32'h100; bus.mem_gnt = 1'b1;
    sample();
    check("fetch_if_gnt",   64'(bus.if_gnt),   64'd1);
    check("fetch_ls_gnt",   64'(bus.ls_gnt),   64'd0);
    check("fetch_mem_req",  64'(bus.mem_req),  64'd1);
    check("fetch_mem_addr", 64'(bus.mem_addr), 64'h100);
    check("fetch_mem_we",   64'(bus.mem_we),   64'd0);
    check("fetch_mem_be",   64'(bus.mem_be),   64'hF);
    tick();
    quiet();
    bus.if_req = 1'b1; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hDEADBEEF;
    sample();
    check("fetch_if_rvalid", 64'(bus.if_rvalid), 64'd1);
    check("fetch_if_rdata",  64'(bus.if_rdata),  64'hDEADBEEF);
    check("fetch_busy_req",  64'(bus.mem_req),   64'd0);
    check("fetch_busy_gnt",  64'(bus.if_gnt),    64'd0);
    tick();
    quiet();

    // Stray response in IDLE is ignored.
    bus.mem_rvalid = 1'b1;
    sample();
    check("idle_rv_if", 64'(bus.if_rvalid), 64'd0);
    check("idle_rv_ls", 64'(bus.ls_rvalid), 64'd0);
    tick();
    quiet();
    bus.ls_req = 1'b1;
    sample();
    check("idle_rv_stay_idle", 64'(bus.mem_req), 64'd1);
    tick();
    quiet();

    // Store; flush in BUSY_LS has no effect.
    bus.ls_req = 1'b1; bus.ls_we = 1'b1; bus.ls_addr = 32'h2000;
    bus.ls_wdata = 32'h12345678; bus.ls_be = 4'b0011; bus.mem_gnt = 1'b1;
    sample();
    check("store_ls_gnt",    64'(bus.ls_gnt),    64'd1);
    check("store_if_gnt",    64'(bus.if_gnt),    64'd0);
    check("store_mem_we",    64'(bus.mem_we),    64'd1);
    check("store_mem_addr",  64'(bus.mem_addr),  64'h2000);
    check("store_mem_wdata", 64'(bus.mem_wdata), 64'h12345678);
    check("store_mem_be",    64'(bus.mem_be),    64'h3);
    tick();
    quiet();
    bus.flush = 1'b1;
    sample();
    check("store_wait_rvalid", 64'(bus.ls_rvalid), 64'd0);
    tick();
    quiet();
    bus.mem_rvalid = 1'b1;
    sample();
    check("store_ack", 64'(bus.ls_rvalid), 64'd1);
    tick();
    quiet();
    sample();
    check("store_ack_once", 64'(bus.ls_rvalid), 64'd0);
    tick();

    // Conflict: LS, LS, LS, IF, ...
    for (int i = 0; i < 8; i++) begin
      quiet();
      bus.if_req = 1'b1; bus.if_addr = 32'h300; bus.ls_req = 1'b1;
      bus.ls_addr = 32'h400; bus.mem_gnt = 1'b1;
      sample();
      check($sformatf("conf%0d_if_gnt", i), 64'(bus.if_gnt), 64'(exp_if_grant[i]));
      check($sformatf("conf%0d_ls_gnt", i), 64'(bus.ls_gnt), 64'(!exp_if_grant[i]));
      tick();
      bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hA0 + 32'(i);
      sample();
      check($sformatf("conf%0d_starve", i), 64'(dut.starve_q), 64'(exp_starve[i]));
      check($sformatf("conf%0d_if_rv", i), 64'(bus.if_rvalid), 64'(exp_if_grant[i]));
      check($sformatf("conf%0d_ls_rv", i), 64'(bus.ls_rvalid), 64'(!exp_if_grant[i]));
      tick();
    end
    quiet();

    // Flush one cycle after grant, response three cycles after grant.
    bus.if_req = 1'b1; bus.if_addr = 32'h500; bus.mem_gnt = 1'b1;
    sample();
    check("fl_gnt", 64'(bus.if_gnt), 64'd1);
    tick();
    quiet();
    bus.flush = 1'b1;
    tick();
    quiet();
    tick();
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h55;
    sample();
    check("fl_suppressed", 64'(bus.if_rvalid), 64'd0);
    tick();
    quiet();
    bus.if_req = 1'b1; bus.if_addr = 32'h504; bus.mem_gnt = 1'b1;
    sample();
    check("fl_next_gnt", 64'(bus.if_gnt), 64'd1);
    tick();
    quiet();
    bus.mem_rvalid = 1'b1;
    sample();
    check("fl_next_rvalid", 64'(bus.if_rvalid), 64'd1);
    tick();
    quiet();

    // Flush coinciding with the response cycle.
    bus.if_req = 1'b1; bus.mem_gnt = 1'b1;
    tick();
    quiet();
    bus.mem_rvalid = 1'b1; bus.flush = 1'b1;
    sample();
    check("fl_resp_cycle", 64'(bus.if_rvalid), 64'd0);
    tick();
    quiet();

    // Flush coinciding with the IF handshake.
    bus.if_req = 1'b1; bus.mem_gnt = 1'b1; bus.flush = 1'b1;
    sample();
    check("fl_hs_gnt", 64'(bus.if_gnt), 64'd1);
    tick();
    quiet();
    bus.mem_rvalid = 1'b1;
    sample();
    check("fl_hs_drop", 64'(bus.if_rvalid), 64'd0);
    tick();
    quiet();

    // Backpressure, then reset in BUSY_LS.
    bus.ls_req = 1'b1; bus.ls_addr = 32'h40;
    for (int i = 0; i < 4; i++) begin
      sample();
      check($sformatf("bp%0d_ls_gnt", i), 64'(bus.ls_gnt), 64'd0);
      check($sformatf("bp%0d_mem_req", i), 64'(bus.mem_req), 64'd1);
      tick();
    end
    bus.mem_gnt = 1'b1;
    sample();
    check("bp_ls_gnt", 64'(bus.ls_gnt), 64'd1);
    tick();
    quiet();
    bus.ls_req = 1'b1; bus.if_req = 1'b1; bus.mem_gnt = 1'b1; bus.mem_rvalid = 1'b1;
    rst = 1'b0;
    sample();
    check("rst_busy_mem_req", 64'(bus.mem_req),   64'd0);
    check("rst_busy_ls_gnt",  64'(bus.ls_gnt),    64'd0);
    check("rst_busy_if_gnt",  64'(bus.if_gnt),    64'd0);
    check("rst_busy_ls_rv",   64'(bus.ls_rvalid), 64'd0);
    check("rst_busy_if_rv",   64'(bus.if_rvalid), 64'd0);
    tick();
    quiet();
    rst = 1'b1;
    bus.mem_rvalid = 1'b1;
    sample();
    check("late_rv_ls", 64'(bus.ls_rvalid), 64'd0);
    tick();
    quiet();
    bus.ls_req = 1'b1; bus.mem_gnt = 1'b1;
    sample();
    check("post_rst_ls_gnt", 64'(bus.ls_gnt), 64'd1);
    tick();
    quiet();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_WIDTH, default 32, address width; DATA_WIDTH, default 32, data width; STARVE_LIMIT, default 3, number of consecutive LS grants allowed while IF waits.
REQ-002 The ports SHALL be, as name direction width meaning:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-low.
- if_req  in  1  fetch read request.
- if_addr  in  ADDR_WIDTH  fetch address (PC).
- if_gnt  out  1  fetch request accepted this cycle.
- if_rvalid  out  1  fetch read data valid.
- if_rdata  out  DATA_WIDTH  fetch read data.
- flush  in  1  branch or redirect; discard the pending fetch response.
- ls_req  in  1  load/store request.
- ls_we  in  1  1 = store, 0 = load.
- ls_addr  in  ADDR_WIDTH  load/store address.
- ls_wdata  in  DATA_WIDTH  store data.
- ls_be  in  DATA_WIDTH/8  byte enables.
- ls_gnt  out  1  load/store request accepted this cycle.
- ls_rvalid  out  1  load data valid, or store acknowledge.
- ls_rdata  out  DATA_WIDTH  load data.
- mem_req  out  1  request to the shared memory port.
- mem_we, mem_addr, mem_wdata, mem_be  out  1 / ADDR_WIDTH / DATA_WIDTH / DATA_WIDTH/8  muxed request fields.
- mem_gnt  in  1  memory accepts the request.
- mem_rvalid  in  1  memory response valid; sent for both loads and stores.
- mem_rdata  in  DATA_WIDTH  memory read data.

Function
REQ-003 The FSM SHALL have three states: IDLE, BUSY_IF and BUSY_LS; at most one transaction is outstanding.
REQ-004 In IDLE, mem_req SHALL be asserted combinationally when if_req or ls_req is high.
REQ-005 In IDLE, mem_we, mem_addr, mem_wdata and mem_be SHALL be driven from the selected requester.
REQ-006 When IF is selected, mem_we SHALL be 0 and mem_be SHALL be all ones.
REQ-007 Selection SHALL give LS priority over IF, except when starve_cnt equals STARVE_LIMIT and if_req is high; then IF SHALL be selected.
REQ-008 starve_cnt SHALL be a 2-bit counter with these rules:
- increment on each LS handshake while if_req is high;
- saturate at STARVE_LIMIT;
- clear on each IF handshake;
- hold otherwise.
REQ-009 A handshake SHALL occur when mem_req and mem_gnt are both high in IDLE.
REQ-010 The selected requester's gnt SHALL equal mem_gnt in that cycle; the other gnt SHALL be 0.
REQ-011 After a handshake, the next state SHALL be BUSY_IF or BUSY_LS, matching the selected requester.
REQ-012 Without mem_gnt, the FSM SHALL stay in IDLE and selection SHALL be re-evaluated next cycle; requesters hold their request fields until gnt.
REQ-013 In BUSY_IF and BUSY_LS, mem_req, if_gnt and ls_gnt SHALL be 0.
REQ-014 In BUSY_x, mem_rvalid SHALL return the FSM to IDLE on the next edge.
REQ-015 In the mem_rvalid cycle, x_rvalid SHALL be 1 for exactly that cycle; the earliest next mem_req is the following cycle.
REQ-016 Latency SHALL be 1 cycle minimum from handshake to rvalid when memory responds on the next cycle.
REQ-017 The issue-to-issue gap SHALL be 2 cycles minimum.
REQ-018 if_rdata and ls_rdata SHALL pass mem_rdata through combinationally; their value is meaningful only when the matching rvalid is 1.
REQ-019 The drop flag SHALL set on flush in BUSY_IF, or on flush coinciding with an IF handshake.
REQ-020 While drop is set, the response SHALL complete the FSM transition, but if_rvalid SHALL be forced to 0 and drop SHALL clear.
REQ-021 A flush coinciding with the response cycle SHALL suppress that if_rvalid.
REQ-022 Flush SHALL have no effect in IDLE without a handshake, and no effect in BUSY_LS.
REQ-023 mem_rvalid in IDLE SHALL be ignored: no rvalid output and no state change.
REQ-024 Flush SHALL never affect LS transactions or starve_cnt.

Reset
REQ-025 While rst = 0 at a rising edge, the block SHALL load state = IDLE, starve_cnt = 0 and drop = 0.
REQ-026 While rst = 0, mem_req, if_gnt, ls_gnt, if_rvalid and ls_rvalid SHALL be forced to 0, regardless of inputs.
REQ-027 Reset asserted mid-transaction SHALL abandon the transaction, and a late mem_rvalid arriving in IDLE SHALL be ignored per REQ-023.

Verification
REQ-028 Scenario, simple fetch: if_req = 1, if_addr = 0x100, mem_gnt = 1, mem_rvalid one cycle later with 0xDEADBEEF -> if_gnt = 1 at cycle 0; if_rvalid = 1 with if_rdata = 0xDEADBEEF at cycle 1; mem_req = 0 at cycle 1.
REQ-029 Scenario, conflict: if_req and ls_req both held high, ls_we = 0, memory always grants and responds next cycle -> grant sequence LS, LS, LS, IF, LS, LS, LS, IF; starve_cnt returns to 0 after each IF grant.
REQ-030 Scenario, store: ls_req = 1, ls_we = 1, ls_addr = 0x2000, ls_wdata = 0x12345678, ls_be = 0b0011 -> these values appear on mem_* with mem_we = 1; ls_rvalid pulses once on mem_rvalid.
REQ-031 Scenario, flush in BUSY_IF: memory responds 3 cycles after grant, flush pulses 1 cycle after grant -> if_rvalid stays 0; the FSM is in IDLE after the response; the next if_req is granted normally.
REQ-032 Scenario, backpressure and reset: mem_gnt = 0 for 4 cycles with ls_req held -> ls_gnt = 0 and the state stays IDLE. Then grant, and drive rst = 0 in BUSY_LS -> outputs go to 0; a subsequent mem_rvalid produces no ls_rvalid.
